// File: rtl/spy_playback_controller.sv
// Spy buffer sequencer: forwards upstream words into a circular memory while recording,
// then on freeze replays the captured history oldest-first on a valid/ready stream.
module spy_playback_controller #(
    parameter int WIDTH     = 6,
    parameter int DATAWIDTH = 32,
    parameter int DROPWIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 freeze_req,
    output logic                 mem_write_enable,
    output logic [DATAWIDTH-1:0] mem_write_data,
    input  logic [WIDTH-1:0]     mem_write_pointer,
    output logic                 mem_read_enable,
    output logic [WIDTH-1:0]     mem_read_addr,
    input  logic [DATAWIDTH-1:0] mem_read_data,
    output logic                 out_valid,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 frozen,
    output logic [DROPWIDTH-1:0] dropped
);

    localparam int             SIZE     = 1 << WIDTH;
    localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(SIZE - 1);
    localparam logic [WIDTH:0]   FULL_CNT  = (WIDTH+1)'(SIZE);

    typedef enum logic [2:0] {RECORD, FREEZE, ISSUE, FETCH, PRESENT} state_t;

    state_t               state_q, state_d;
    logic                 wrapped_q, wrapped_d;
    logic [WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
    logic [WIDTH:0]       remaining_q, remaining_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATAWIDTH-1:0] out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
    logic [DROPWIDTH-1:0] dropped_q, dropped_d;

    assign mem_write_enable = in_valid && (state_q == RECORD);
    assign mem_write_data   = in_data;
    assign mem_read_enable  = (state_q == ISSUE);
    assign mem_read_addr    = rd_ptr_q;
    assign out_valid        = out_valid_q;
    assign out_data         = out_data_q;
    assign out_last         = out_last_q;
    assign frozen           = (state_q != RECORD);
    assign dropped          = dropped_q;

    always_comb begin
        state_d     = state_q;
        wrapped_d   = wrapped_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        dropped_d   = dropped_q;

        if (mem_write_enable && mem_write_pointer == LAST_ADDR)
            wrapped_d = 1'b1;
        if (frozen && in_valid && dropped_q != {DROPWIDTH{1'b1}})
            dropped_d = dropped_q + 1'b1;

        case (state_q)
            RECORD: begin
                if (freeze_req) begin
                    state_d   = FREEZE;
                    dropped_d = '0;
                end
            end
            FREEZE: begin
                // Once wrapped the whole ring is valid and the oldest word sits at the write pointer.
                if (wrapped_q) begin
                    rd_ptr_d    = mem_write_pointer;
                    remaining_d = FULL_CNT;
                end else begin
                    rd_ptr_d    = '0;
                    remaining_d = {1'b0, mem_write_pointer};
                end
                state_d = (remaining_d == '0) ? RECORD : ISSUE;
            end
            ISSUE: state_d = FETCH;
            FETCH: begin
                out_data_d  = mem_read_data;
                out_valid_d = 1'b1;
                out_last_d  = (remaining_q == 1);
                state_d     = PRESENT;
            end
            PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (remaining_q == 1) begin
                        state_d = RECORD;
                    end else begin
                        rd_ptr_d    = rd_ptr_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        state_d     = ISSUE;
                    end
                end
            end
            default: state_d = RECORD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RECORD;
            wrapped_q   <= 1'b0;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            dropped_q   <= '0;
        end else begin
            state_q     <= state_d;
            wrapped_q   <= wrapped_d;
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            dropped_q   <= dropped_d;
        end
    end

endmodule

// File: tb/tb_spy_playback_controller.sv
// Randomized bench for spy_playback_controller with a ring-memory model and a
// history-queue reference of what each freeze must replay.
module tb_spy_playback_controller;

    localparam int WIDTH = 3;
    localparam int DW    = 32;
    localparam int DROPW = 4;
    localparam int SIZE  = 1 << WIDTH;
    localparam int DMAX  = (1 << DROPW) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic             freeze_req;
    logic             mem_write_enable;
    logic [DW-1:0]    mem_write_data;
    logic [WIDTH-1:0] mem_write_pointer;
    logic             mem_read_enable;
    logic [WIDTH-1:0] mem_read_addr;
    logic [DW-1:0]    mem_read_data;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_last;
    logic             out_ready;
    logic             frozen;
    logic [DROPW-1:0] dropped;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] hist[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mem [SIZE];

    spy_playback_controller #(.WIDTH(WIDTH), .DATAWIDTH(DW), .DROPWIDTH(DROPW)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .freeze_req(freeze_req), .mem_write_enable(mem_write_enable),
        .mem_write_data(mem_write_data), .mem_write_pointer(mem_write_pointer),
        .mem_read_enable(mem_read_enable), .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .frozen(frozen), .dropped(dropped)
    );

    always #5 clock = ~clock;

    // Spy memory: circular write pointer, one-cycle registered read.
    always @(posedge clock) begin
        if (reset) begin
            mem_write_pointer <= '0;
        end else begin
            if (mem_write_enable) begin
                mem[mem_write_pointer] <= mem_write_data;
                mem_write_pointer      <= mem_write_pointer + 1'b1;
            end
            if (mem_read_enable) mem_read_data <= mem[mem_read_addr];
        end
    end

    task automatic chk(input string tag, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Stream scoreboard and hold-stability checks, sampled mid-cycle.
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    always @(negedge clock) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_d);
                chk("hold_last", out_last, prev_l);
            end
            if (!out_valid) chk("last_idle", out_last, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 1, 0);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    chk("data", out_data, e);
                    chk("last", out_last, exp_q.size() == 0);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_d    = out_data;
            prev_l    = out_last;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        hist.delete();
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        chk("wen", mem_write_enable, 1);
        chk("wdata", mem_write_data, d);
        hist.push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    // Replay expected: the newest min(n, SIZE) words since reset, oldest first.
    task automatic build_expect(output int m, output int start);
        int n;
        n = hist.size();
        m = (n < SIZE) ? n : SIZE;
        start = (n >= SIZE) ? (n % SIZE) : 0;
        exp_q.delete();
        for (int i = n - m; i < n; i++) exp_q.push_back(hist[i]);
    endtask

    // mode 0: ready high; mode 1: random ready/in_valid; mode 2: stall `stall` cycles with in_valid
    task automatic do_freeze(input logic with_wr, input logic [DW-1:0] wd, input int mode, input int stall);
        int m, start, exp_drops, rd_cnt, stalls, first_v, end_c, scnt;
        logic iv;
        freeze_req = 1'b1;
        if (with_wr) begin
            in_valid = 1'b1;
            in_data  = wd;
            hist.push_back(wd);
            #1;
            chk("wen_frzreq", mem_write_enable, 1);
        end
        build_expect(m, start);
        tick();
        freeze_req = 1'b0;
        in_valid   = 1'b0;
        exp_drops = 0; rd_cnt = 0; stalls = 0; first_v = -1; end_c = -1; scnt = 0;
        for (int c = 0; c < 400; c++) begin
            if (c == 0) chk("drop_clr", dropped, 0);
            if (!frozen) begin
                end_c = c;
                break;
            end
            if (mem_read_enable) rd_cnt++;
            if (c == 1 && m > 0) chk("rd_addr", mem_read_addr, start);
            if (out_valid && first_v < 0) first_v = c;
            case (mode)
                0: begin out_ready = 1'b1; iv = 1'b0; end
                1: begin out_ready = ($urandom_range(0, 3) != 0); iv = $urandom_range(0, 1); end
                default: begin
                    if (first_v >= 0 && scnt < stall) begin
                        out_ready = 1'b0; iv = 1'b1; scnt++;
                    end else begin
                        out_ready = 1'b1; iv = 1'b0;
                    end
                end
            endcase
            in_valid = iv;
            in_data  = $urandom;
            if (iv && exp_drops < DMAX) exp_drops++;
            #1;
            if (iv) chk("wen_frozen", mem_write_enable, 0);
            if (out_valid && !out_ready) stalls++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (end_c < 0) begin
            chk("timeout", 0, 1);
        end else begin
            chk("frozen_len", end_c, (m == 0) ? 1 : 3 * m + 1 + stalls);
            chk("first_valid", first_v, (m == 0) ? -1 : 3);
            chk("rd_count", rd_cnt, m);
            chk("words_left", exp_q.size(), 0);
            chk("dropped", dropped, exp_drops);
            chk("valid_after", out_valid, 0);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; freeze_req = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_dropped", dropped, 0);
        chk("rst_frozen", frozen, 0);
        chk("rst_ren", mem_read_enable, 0);
        chk("rst_raddr", mem_read_addr, 0);
        chk("rst_wen", mem_write_enable, 0);
        reset = 1'b0;
        tick();

        // empty freeze: one FREEZE cycle, no reads, no output
        do_freeze(1'b0, '0, 0, 0);

        // five words, no wrap
        for (int i = 0; i < 5; i++) wr(32'hA0 + i);
        do_freeze(1'b0, '0, 0, 0);

        // wrapped ring: 1..11 replays 4..11 from address 3
        do_reset();
        for (int i = 1; i <= 11; i++) wr(i);
        do_freeze(1'b0, '0, 0, 0);

        // backpressure with drops, next freeze clears count, then saturation
        do_freeze(1'b0, '0, 2, 10);
        do_freeze(1'b0, '0, 0, 0);
        do_freeze(1'b0, '0, 2, 20);

        // write coinciding with freeze_req lands in the snapshot
        do_reset();
        wr(32'h10);
        wr(32'h11);
        do_freeze(1'b1, 32'h55, 0, 0);
        chk("mem2", mem[2], 32'h55);

        // reset in the middle of playback after a wrapped history
        for (int i = 0; i < 9; i++) wr($urandom);
        freeze_req = 1'b1;
        tick();
        freeze_req = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                in_valid = 1'b1;
                if (out_valid) seen = 1'b1;
                else tick();
            end
            chk("mid_wait", seen, 1);
        end
        in_valid = 1'b0;
        do_reset();
        chk("mid_valid", out_valid, 0);
        chk("mid_frozen", frozen, 0);
        chk("mid_dropped", dropped, 0);
        chk("mid_last", out_last, 0);
        chk("mid_ren", mem_read_enable, 0);
        wr(32'hC1);
        wr(32'hC2);
        do_freeze(1'b0, '0, 0, 0);

        // random recording bursts and random-backpressure playbacks
        for (int it = 0; it < 8; it++) begin
            int k;
            k = $urandom_range(0, 12);
            for (int j = 0; j < k; j++) begin
                if ($urandom_range(0, 3) == 0) tick();
                wr($urandom);
            end
            do_freeze(logic'($urandom_range(0, 1)), $urandom, 1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
